// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_if
//  Purpose  : Requester-side handshake bundle for sram_ctrl. Carries the word
//             address, level-held read/write requests, the needWait response
//             and, with SRAM_BYTE_LANES_EN defined, the byte-enable pair.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] addr_i;
    logic              re_i;
    logic              we_i;
    logic              needWait_o;
`ifdef SRAM_BYTE_LANES_EN
    logic [1:0]        be_i;
`endif

    // Requester side: drives the request, watches needWait.
    modport master (
        output addr_i,
        output re_i,
        output we_i,
`ifdef SRAM_BYTE_LANES_EN
        output be_i,
`endif
        input  needWait_o
    );

    // Controller side.
    modport slave (
        input  addr_i,
        input  re_i,
        input  we_i,
`ifdef SRAM_BYTE_LANES_EN
        input  be_i,
`endif
        output needWait_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Turns the level-held re/we + needWait handshake into timed
//             asynchronous SRAM cycles (16-bit words). OE_N / WE_N are held
//             active for WAIT_CYCLES clocks to cover SRAM access time.
//             Optional macro SRAM_BYTE_LANES_EN adds per-byte enables (be_i).
//  Revision : 1.0  initial release
// ============================================================================
module sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2      // legal range 1..15
) (
    input  wire               clk,
    input  wire               rst,
    sram_ctrl_if.slave        bus,
    inout  wire [15:0]        data_io,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire [15:0]        sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Counter is loaded one below the wait count so it ends on zero.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              rd_q, rd_d;       // current access is a read
    logic              access;           // SRAM cycle in progress
    logic              dq_oe;
    logic              io_oe;
`ifdef SRAM_BYTE_LANES_EN
    logic [1:0]        be_q, be_d;
`endif

    // Tri-state enables come straight from registered state so the SRAM
    // read-data path never loops back through the next-state logic.
    assign dq_oe = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                   (state_q == S_WR_HOLD);
    assign io_oe = (state_q == S_DONE) && rd_q && bus.re_i;

    assign sram_dq     = dq_oe ? wdata_q : 16'hzzzz;
    assign data_io     = io_oe ? rdata_q : 16'hzzzz;
    assign sram_addr_o = addr_q;

    // Busy whenever a request is present, except in the completion cycle.
    assign bus.needWait_o = (bus.re_i | bus.we_i) && (state_q != S_DONE);

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            rd_q    <= 1'b0;
`ifdef SRAM_BYTE_LANES_EN
            be_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
`ifdef SRAM_BYTE_LANES_EN
            be_q    <= be_d;
`endif
        end
    end

    // Next-state logic and SRAM strobe decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
`ifdef SRAM_BYTE_LANES_EN
        be_d      = be_q;
`endif
        access    = 1'b0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;

        case (state_q)
            S_IDLE: begin
                // Write wins when both requests are raised together.
                if (bus.we_i || bus.re_i) begin
                    addr_d  = bus.addr_i;
                    wdata_d = data_io;
                    cnt_d   = CNT_INIT;
                    rd_d    = !bus.we_i;
`ifdef SRAM_BYTE_LANES_EN
                    be_d    = bus.be_i;
`endif
                    state_d = bus.we_i ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                access    = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (!bus.re_i) begin
                    // Requester gave up: abandon without a completion cycle.
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    rdata_d = sram_dq;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_SETUP: begin
                access    = 1'b1;
                sram_ce_n = 1'b0;
                state_d   = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                // Runs to completion even if we_i drops, so WE_N is never cut short.
                access    = 1'b1;
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_HOLD: begin
                access    = 1'b1;
                sram_ce_n = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SRAM_BYTE_LANES_EN
        sram_ub_n = access ? ~be_q[1] : 1'b1;
        sram_lb_n = access ? ~be_q[0] : 1'b1;
`else
        sram_ub_n = ~access;
        sram_lb_n = ~access;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Purpose  : Self-checking bench for sram_ctrl: directed and random accesses
//             against a word-level reference memory, scoreboard-checked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;
    localparam int ADDR_W = 18;
    localparam int W      = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    // Pulled-up buses: an undriven bus reads as all ones.
    tri1 [15:0] data_io;
    tri1 [15:0] sram_dq;

    logic [ADDR_W-1:0] sram_addr_o;
    logic sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] tb_wd;

    assign data_io = bus.we_i ? tb_wd : 16'hzzzz;

    sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .data_io     (data_io),
        .sram_addr_o (sram_addr_o),
        .sram_dq     (sram_dq),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    // ---------------- SRAM device model ----------------
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr_o] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr_o][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr_o][7:0]  <= sram_dq[7:0];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit                is_rd;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        be;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [int];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   nw_cnt, oe_cnt, we_cnt;
    bit   m_req, m_done;
    exp_t m_e;
    always @(negedge clk) begin
        if (rst) begin
            nw_cnt = 0; oe_cnt = 0; we_cnt = 0;
        end else begin
            m_req  = bus.re_i | bus.we_i;
            m_done = m_req && !bus.needWait_o;
            if (!sram_ce_n) begin
                if (exp_q.size() > 0) begin
                    check("sram_addr", 32'(sram_addr_o), 32'(exp_q[0].addr));
                    check("byte_lanes", {30'd0, sram_ub_n, sram_lb_n}, {30'd0, ~exp_q[0].be});
                    if (!exp_q[0].is_rd) begin
                        check("wr_dq", {16'd0, sram_dq}, {16'd0, exp_q[0].data});
                        check("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
                    end
                end
            end else begin
                check("idle_ctrl", {28'd0, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'hF);
                check("idle_dq_z", {16'd0, sram_dq}, 32'hFFFF);
            end
            if (!m_done && !bus.we_i)
                check("data_io_z", {16'd0, data_io}, 32'hFFFF);
            if (m_req && bus.needWait_o) nw_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got completion expected none at %0t", $time);
                end else begin
                    m_e = exp_q.pop_front();
                    if (m_e.is_rd) begin
                        check("rd_needwait", 32'(nw_cnt), 32'(W + 1));
                        check("rd_oe_cycles", 32'(oe_cnt), 32'(W));
                        check("rd_data", {16'd0, data_io}, {16'd0, m_e.data});
                    end else begin
                        check("wr_needwait", 32'(nw_cnt), 32'(W + 3));
                        check("wr_we_cycles", 32'(we_cnt), 32'(W));
                        check("wr_no_oe", 32'(oe_cnt), 32'd0);
                    end
                end
                nw_cnt = 0; oe_cnt = 0; we_cnt = 0;
            end else if (!m_req) begin
                nw_cnt = 0; oe_cnt = 0; we_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_be(input logic [1:0] be);
`ifdef SRAM_BYTE_LANES_EN
        bus.be_i = be;
`else
        if (be != 2'b11) $display("note: byte enables ignored in this build");
`endif
    endtask

    task automatic do_req(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input logic [1:0] be, input bit scramble);
        exp_t        e;
        logic [15:0] old;
        bit          done;
        @(posedge clk); #2;
        e.is_rd = rd && !wr;
        e.addr  = a;
        e.be    = be;
        if (wr) begin
            old = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
            ref_mem[int'(a)] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
            e.data = d;
        end else begin
            e.data = ref_mem[int'(a)];
        end
        exp_q.push_back(e);
        bus.addr_i = a; tb_wd = d; set_be(be);
        bus.we_i = wr; bus.re_i = rd;
        done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (!bus.needWait_o) done = 1;
            else if (scramble && n == 1) bus.addr_i = ADDR_W'($urandom);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: got needWait stuck high expected completion at %0t", $time);
            exp_q.delete();
        end
        @(posedge clk); #2;
        bus.we_i = 1'b0; bus.re_i = 1'b0;
    endtask

    logic [ADDR_W-1:0] pool [8];
    logic [1:0]        full_be;

    initial begin
        bool_init();
        full_be = 2'b11;
        rst = 1'b1;
        bus.addr_i = '0; bus.re_i = 1'b0; bus.we_i = 1'b0; tb_wd = 16'h0000;
        set_be(2'b11);

        // Reset with no requests.
        repeat (2) @(posedge clk);
        #2;
        check("rst_needwait", {31'd0, bus.needWait_o}, 32'd0);
        check("rst_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_addr", 32'(sram_addr_o), 32'd0);
        check("rst_dq_z", {16'd0, sram_dq}, 32'hFFFF);
        check("rst_io_z", {16'd0, data_io}, 32'hFFFF);
        rst = 1'b0;

        // Directed write / read-back / simultaneous request.
        do_req(1, 0, 18'h00123, 16'hBEEF, full_be, 0);
        do_req(0, 1, 18'h00123, 16'h0000, full_be, 0);
        do_req(1, 1, 18'h3FFFF, 16'h1234, full_be, 0);
        do_req(0, 1, 18'h3FFFF, 16'h0000, full_be, 0);

        // Reset during the write pulse.
        @(posedge clk); #2;
        exp_q.push_back('{is_rd: 1'b0, addr: 18'h2AAAA, data: 16'h5A5A, be: full_be});
        bus.addr_i = 18'h2AAAA; tb_wd = 16'h5A5A; bus.we_i = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (!sram_we_n) break;
        end
        #1 rst = 1'b1;
        @(posedge clk); #2;
        check("abort_ctrl", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check("abort_dq_z", {16'd0, sram_dq}, 32'hFFFF);
        bus.we_i = 1'b0;
        void'(exp_q.pop_back());
        #1 check("abort_needwait", {31'd0, bus.needWait_o}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        do_req(0, 1, 18'h00123, 16'h0000, full_be, 0);

        // Read abandoned after one RD cycle: no completion, no data.
        @(posedge clk); #2;
        bus.addr_i = 18'h00123; bus.re_i = 1'b1;
        @(posedge clk); #2;
        bus.re_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("drop_oe_n", {31'd0, sram_oe_n}, 32'd1);

`ifdef SRAM_BYTE_LANES_EN
        // Upper byte only: lower byte of the stored word must survive.
        do_req(1, 0, 18'h01000, 16'h1177, 2'b11, 0);
        do_req(1, 0, 18'h01000, 16'hAA55, 2'b10, 0);
        do_req(0, 1, 18'h01000, 16'h0000, 2'b11, 0);
        do_req(1, 0, 18'h01000, 16'hFFFF, 2'b00, 0);
        do_req(0, 1, 18'h01000, 16'h0000, 2'b01, 0);
`endif

        // Randomized traffic over a small address pool.
        for (int k = 0; k < 8; k++) pool[k] = ADDR_W'($urandom);
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] a;
            logic [1:0]        be;
            int                op;
            a  = pool[$urandom_range(0, 7)];
            op = $urandom_range(0, 2);
            be = 2'b11;
            if (!ref_mem.exists(int'(a))) op = 1;
`ifdef SRAM_BYTE_LANES_EN
            else be = 2'($urandom);
`endif
            do_req(op != 0, op != 1, a, 16'($urandom), be, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #2 check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic bool_init();
        nw_cnt = 0; oe_cnt = 0; we_cnt = 0;
    endtask

    // Hard stop if something wedges beyond every per-request bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
